seg_capture_decoder: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment decoder. Monitors a multiplexed 8-digit seven-segment bus (segment lines plus active-low digit selects) and reconstructs the BCD value shown on each digit. Each digit is captured only after its segment and select pattern has been stable for a programmable number of cycles. Used by the lab self-check harness and the scan-display verification bench to read back what the display logic drives.

---
 rtl/seg_capture_decoder_if.sv | 31 +++
 rtl/seg_capture_decoder.sv | 128 ++++++++++++
 tb/tb_seg_capture_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_capture_decoder_if.sv
// seg_capture_decoder_if
//   Bundles the multiplexed seven-segment bus that is being observed together
//   with the values reconstructed from it.
//   master : whoever drives the display bus and reads the results back
//   slave  : the capture decoder
//   seg        [7:0]  segment lines, active-high (bit0=a .. bit6=g, bit7=dp)
//   dig_sel    [7:0]  digit selects, active-low
//   bcd_out    [31:0] captured value, digit i in [4i+3:4i]
//   dp_out     [7:0]  captured decimal point per digit
//   valid      [7:0]  digit captured at least once since reset
//   err        [7:0]  last capture of the digit was an unrecognised pattern
//   frame_done        one-cycle pulse when a full set of 8 digits completes
interface seg_capture_decoder_if;
    logic [7:0]  seg;
    logic [7:0]  dig_sel;
    logic [31:0] bcd_out;
    logic [7:0]  dp_out;
    logic [7:0]  valid;
    logic [7:0]  err;
    logic        frame_done;

    modport master (
        output seg, dig_sel,
        input  bcd_out, dp_out, valid, err, frame_done
    );

    modport slave (
        input  seg, dig_sel,
        output bcd_out, dp_out, valid, err, frame_done
    );
endinterface

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder
//   Watches a multiplexed 8-digit seven-segment bus and rebuilds the BCD value
//   shown on each digit. A digit is captured once its select/segment pattern
//   has held unchanged for STABLE_CYC cycles; the window fires once only.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : seg_capture_decoder_if.slave (segment/select in, results out)
//   Parameter:
//     STABLE_CYC : stable cycles required before a capture, 1..255
module seg_capture_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    seg_capture_decoder_if.slave   bus
);
    localparam int unsigned     CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYC);

    logic [7:0]       s_sel_q, s_seg_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic [7:0][3:0]  nib_q;
    logic [7:0]       dp_q, valid_q, err_q;

    logic             same;
    logic [7:0]       sel_n;
    logic             one_sel;
    logic             cap_en;
    logic [7:0]       cap_vec;
    logic [3:0]       dec_nib;
    logic             dec_err;

    // {err, nibble}; blank (all segments off) reads back as F
    function automatic logic [4:0] decode7(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b0, 4'h0};
            7'h06:   r = {1'b0, 4'h1};
            7'h5B:   r = {1'b0, 4'h2};
            7'h4F:   r = {1'b0, 4'h3};
            7'h66:   r = {1'b0, 4'h4};
            7'h6D:   r = {1'b0, 4'h5};
            7'h7D:   r = {1'b0, 4'h6};
            7'h07:   r = {1'b0, 4'h7};
            7'h7F:   r = {1'b0, 4'h8};
            7'h6F:   r = {1'b0, 4'h9};
            7'h00:   r = {1'b0, 4'hF};
            default: r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    // Compare live inputs against last edge's sample: any difference restarts
    // the window on this edge.
    assign same  = ({bus.dig_sel, bus.seg} == {s_sel_q, s_seg_q});

    always_comb begin
        cnt_d = cnt_q;
        if (!same)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    // Exactly one select low. Zero or several low selects are ignored entirely.
    assign sel_n   = ~s_sel_q;
    assign one_sel = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'h01)) == 8'h00);

    // Only the STABLE_CYC-1 -> STABLE_CYC step captures, so a saturated
    // counter never re-captures.
    assign cap_en  = same && (cnt_q == CNT_MAX - 1'b1) && one_sel;
    assign cap_vec = cap_en ? sel_n : 8'h00;

    assign {dec_err, dec_nib} = decode7(s_seg_q[6:0]);

    always_comb begin
        seen_d  = seen_q | cap_vec;
        frame_d = 1'b0;
        if (cap_en && (&seen_d)) begin
            frame_d = 1'b1;
            seen_d  = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_sel_q <= 8'hFF;
            s_seg_q <= 8'h00;
            cnt_q   <= '0;
            seen_q  <= 8'h00;
            frame_q <= 1'b0;
        end else begin
            s_sel_q <= bus.dig_sel;
            s_seg_q <= bus.seg;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
        end
    end

    // Per-digit result registers; only the selected digit is touched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_q   <= '0;
            dp_q    <= 8'h00;
            valid_q <= 8'h00;
            err_q   <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (cap_vec[i]) begin
                    nib_q[i]   <= dec_nib;
                    err_q[i]   <= dec_err;
                    dp_q[i]    <= s_seg_q[7];
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.bcd_out    = nib_q;
    assign bus.dp_out     = dp_q;
    assign bus.valid      = valid_q;
    assign bus.err        = err_q;
    assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed bench for seg_capture_decoder (STABLE_CYC=4 main instance plus a
// STABLE_CYC=1 instance for the shortest window).
module tb_seg_capture_decoder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seg_capture_decoder_if bus  ();
    seg_capture_decoder_if bus1 ();

    seg_capture_decoder #(.STABLE_CYC(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    seg_capture_decoder #(.STABLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [7:0] pat [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dig_sel = 8'hFF;  bus.seg = 8'h00;
        bus1.dig_sel = 8'hFF; bus1.seg = 8'h00;
        #3;
        total++;
        if ({bus.bcd_out, bus.dp_out, bus.valid, bus.err, bus.frame_done} !== 57'd0) begin
            bad++;
            $display("FAIL reset_state: got bcd=%h dp=%h v=%h e=%h fd=%b exp all zero",
                     bus.bcd_out, bus.dp_out, bus.valid, bus.err, bus.frame_done);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_hold_capture();
        bus.dig_sel = 8'hFE; bus.seg = 8'h5B;
        ticks(4);
        total++;
        if (bus.valid !== 8'h00 || bus.bcd_out !== 32'h0) begin
            bad++;
            $display("FAIL hold_early: got v=%h bcd=%h exp v=00 bcd=0", bus.valid, bus.bcd_out);
        end
        tick();
        total++;
        if (bus.bcd_out !== 32'h2 || bus.valid !== 8'h01 || bus.err !== 8'h00) begin
            bad++;
            $display("FAIL hold_capture: got bcd=%h v=%h e=%h exp bcd=2 v=01 e=00",
                     bus.bcd_out, bus.valid, bus.err);
        end
        ticks(5);
        total++;
        if (bus.bcd_out !== 32'h2 || bus.valid !== 8'h01 || bus.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL hold_steady: got bcd=%h v=%h fd=%b exp bcd=2 v=01 fd=0",
                     bus.bcd_out, bus.valid, bus.frame_done);
        end
    endtask

    task automatic test_restart();
        bus.dig_sel = 8'hFB; bus.seg = 8'h6D;
        ticks(3);
        bus.seg = 8'h7D;
        total++;
        if (bus.bcd_out !== 32'h2 || bus.valid !== 8'h01) begin
            bad++;
            $display("FAIL restart_partial: got bcd=%h v=%h exp bcd=2 v=01", bus.bcd_out, bus.valid);
        end
        ticks(4);
        total++;
        if (bus.bcd_out !== 32'h2) begin
            bad++;
            $display("FAIL restart_early: got bcd=%h exp 2", bus.bcd_out);
        end
        tick();
        total++;
        if (bus.bcd_out !== 32'h602 || bus.valid !== 8'h05) begin
            bad++;
            $display("FAIL restart_capture: got bcd=%h v=%h exp bcd=602 v=05", bus.bcd_out, bus.valid);
        end
        tick();
    endtask

    task automatic test_scan(input string name);
        int pulses = 0;
        int pos    = -1;
        for (int d = 0; d < 8; d++) begin
            bus.dig_sel = ~(8'h01 << d);
            bus.seg     = pat[d];
            for (int t = 1; t <= 6; t++) begin
                tick();
                if (bus.frame_done === 1'b1) begin
                    pulses++;
                    pos = d * 6 + t;
                end
            end
        end
        total++;
        if (bus.bcd_out !== 32'h87654321 || bus.valid !== 8'hFF) begin
            bad++;
            $display("FAIL %s_value: got bcd=%h v=%h exp bcd=87654321 v=ff", name, bus.bcd_out, bus.valid);
        end
        total++;
        if (pulses !== 1 || pos !== 47) begin
            bad++;
            $display("FAIL %s_frame: got pulses=%0d at=%0d exp pulses=1 at=47", name, pulses, pos);
        end
    endtask

    task automatic test_err();
        bus.dig_sel = 8'hFD; bus.seg = 8'h49;
        ticks(6);
        total++;
        if (bus.bcd_out !== 32'h876543E1 || bus.err !== 8'h02 || bus.dp_out !== 8'h00) begin
            bad++;
            $display("FAIL err_pattern: got bcd=%h e=%h dp=%h exp bcd=876543e1 e=02 dp=00",
                     bus.bcd_out, bus.err, bus.dp_out);
        end
        bus.seg = 8'hBF;
        ticks(6);
        total++;
        if (bus.bcd_out !== 32'h87654301 || bus.err !== 8'h00 || bus.dp_out !== 8'h02) begin
            bad++;
            $display("FAIL err_clear_dp: got bcd=%h e=%h dp=%h exp bcd=87654301 e=00 dp=02",
                     bus.bcd_out, bus.err, bus.dp_out);
        end
    endtask

    task automatic test_no_capture(input logic [7:0] sel);
        int fd = 0;
        bus.dig_sel = sel; bus.seg = 8'h3F;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.frame_done === 1'b1) fd++;
        end
        total++;
        if (bus.bcd_out !== 32'h87654301 || bus.valid !== 8'hFF || bus.err !== 8'h00 ||
            bus.dp_out !== 8'h02 || fd !== 0) begin
            bad++;
            $display("FAIL no_capture_%h: got bcd=%h v=%h e=%h dp=%h fd=%0d exp bcd=87654301 v=ff e=00 dp=02 fd=0",
                     sel, bus.bcd_out, bus.valid, bus.err, bus.dp_out, fd);
        end
    endtask

    task automatic test_reset_mid();
        bus.dig_sel = 8'hFE; bus.seg = 8'h06;
        ticks(3);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.bcd_out, bus.dp_out, bus.valid, bus.err, bus.frame_done} !== 57'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: got bcd=%h dp=%h v=%h e=%h exp all zero",
                     bus.bcd_out, bus.dp_out, bus.valid, bus.err);
        end
        tick();
        rst = 1'b0;
        ticks(4);
        total++;
        if (bus.valid !== 8'h00 || bus.bcd_out !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_early: got v=%h bcd=%h exp v=00 bcd=0", bus.valid, bus.bcd_out);
        end
        tick();
        total++;
        if (bus.valid !== 8'h01 || bus.bcd_out !== 32'h1) begin
            bad++;
            $display("FAIL reset_mid_capture: got v=%h bcd=%h exp v=01 bcd=1", bus.valid, bus.bcd_out);
        end
    endtask

    task automatic test_stable1();
        bus1.dig_sel = 8'hFE; bus1.seg = 8'h66;
        tick();
        total++;
        if (bus1.valid !== 8'h00) begin
            bad++;
            $display("FAIL stable1_early: got v=%h exp 00", bus1.valid);
        end
        tick();
        total++;
        if (bus1.valid !== 8'h01 || bus1.bcd_out !== 32'h4) begin
            bad++;
            $display("FAIL stable1_capture: got v=%h bcd=%h exp v=01 bcd=4", bus1.valid, bus1.bcd_out);
        end
    endtask

    initial begin
        test_reset();
        test_hold_capture();
        test_restart();
        test_scan("scan1");
        test_scan("scan2");
        test_err();
        test_no_capture(8'hFC);
        test_no_capture(8'hFF);
        test_reset_mid();
        test_stable1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
